mips_controller: RTL and testbench
==================================

// Module: mips_controller
// PURPOSE
//  Multicycle control FSM for the 8-bit MIPS core. It sits directly upstream of the datapath and drives every datapath select/enable.
//  It consumes instr[31:26] (op), instr[5:0] (funct) and the ALU zero flag, and sequences the 4-byte instruction fetch, decode and execute.
//  It also produces the memory read/write strobes for the external memory.
// PARAMETERS
//  OP_RTYPE  6'b000000  R-type opcode (funct-decoded)
//  OP_LB     6'b100000  load byte
//  OP_SB     6'b101000  store byte
//  OP_BEQ    6'b000100  branch if equal
//  OP_J      6'b000010  jump
//  OP_ADDI   6'b001000  add immediate
// PORTS
//  clk        in   1  clock, all state changes on rising edge
//  rst        in   1  synchronous reset, active high
//  op         in   6  instr[31:26]
//  funct      in   6  instr[5:0]
//  zero       in   1  ALU result == 0
//  memread    out  1  memory read strobe
//  memwrite   out  1  memory write strobe
//  alusrca    out  1  0 = PC, 1 = register A
//  alusrcb    out  2  00 = reg B, 01 = const 1, 10 = imm, 11 = imm<<2
//  pcsource   out  2  00 = ALU result, 01 = aluout, 10 = jump target, 11 = unused
//  iord       out  1  address: 0 = PC, 1 = aluout
//  memtoreg   out  1  write data: 0 = aluout, 1 = mem data reg
//  regdst     out  1  write reg: 0 = rt, 1 = rd
//  regwrite   out  1  register file write enable
//  irwrite    out  4  one-hot byte enable into the IR
//  pcen       out  1  PC enable = pcwrite | (branch & zero)
//  alucont    out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
//  illegal_op out  1  one-cycle pulse when op is unrecognized
// BEHAVIOUR
//  - 4-bit state register; outputs are Moore-decoded from state, except pcen, which also depends on zero.
//  - Encoding: FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7,
//    SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13, ADDIWR=14. Code 15 -> FETCH1.
//  - rst=1: state <= FETCH1 at the edge. While rst is high, every output is forced to 0.
//  - Any output not listed for a state is 0.
//  - FETCHn (n=1..4): memread=1, irwrite=1<<(n-1), alusrcb=01, pcsource=00, pcwrite=1, aluop add.
//    FETCHn -> FETCHn+1; FETCH4 -> DECODE.
//  - DECODE: alusrcb=11, aluop add (precomputes the branch target). Next state by op:
//    LB/SB -> MEMADR, RTYPE -> RTYPEEX, BEQ -> BEQEX, J -> JEX, ADDI -> ADDIEX.
//    Any other op -> FETCH1 with illegal_op=1 for that cycle; the PC keeps advancing.
//  - MEMADR: alusrca=1, alusrcb=10, add. Goes to LBRD if op==LB, else SBWR.
//  - LBRD: memread=1, iord=1 -> LBWR.
//  - LBWR: regwrite=1, memtoreg=1, regdst=0 -> FETCH1.
//  - SBWR: memwrite=1, iord=1 -> FETCH1.
//  - RTYPEEX: alusrca=1, alusrcb=00, funct decode -> RTYPEWR.
//  - RTYPEWR: regwrite=1, regdst=1, memtoreg=0 -> FETCH1.
//  - BEQEX: alusrca=1, alusrcb=00, sub, pcsource=01, branch=1 -> FETCH1.
//  - JEX: pcsource=10, pcwrite=1 -> FETCH1.
//  - ADDIEX: alusrca=1, alusrcb=10, add -> ADDIWR.
//  - ADDIWR: regwrite=1, regdst=0, memtoreg=0 -> FETCH1.
//  - alucont: aluop add -> 010, sub -> 110.
//    Funct decode: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, other -> 010.
//  - pcen is combinational and is valid in the same cycle as zero. branch=1 with zero=0 gives pcen=0.
//  - op and funct are sampled only in DECODE, MEMADR and RTYPEEX. They are stable because irwrite=0 there.
//  - Latency per instruction, in cycles: LB 8, SB 7, R-type 7, ADDI 7, BEQ 6, J 6, illegal 5.
//  - rst asserted mid-instruction: abort; FETCH1 follows the next edge with no memwrite/regwrite issued after it.
// TESTING
//  1. Hold rst 3 cycles -> all outputs 0. Release -> FETCH1: memread=1, irwrite=0001, pcen=1.
//     Following cycles irwrite = 0010, 0100, 1000, then DECODE with alusrcb=11.
//  2. op=000000, funct=101010 -> RTYPEEX alucont=111, alusrca=1.
//     RTYPEWR regwrite=1, regdst=1, then FETCH1; 7 cycles total.
//  3. op=100000 (LB) -> MEMADR alusrcb=10, LBRD memread=1 iord=1, LBWR regwrite=1 memtoreg=1, then FETCH1.
//     op=101000 (SB) -> SBWR memwrite=1 iord=1, then FETCH1.
//  4. op=000100, BEQEX: zero=1 -> pcen=1, pcsource=01, alucont=110. zero=0 -> pcen=0. Both return to FETCH1.
//  5. op=000010 -> JEX pcen=1, pcsource=10.
//     op=111111 -> DECODE pulses illegal_op=1, next FETCH1, no regwrite/memwrite.
//  6. Assert rst in SBWR and in RTYPEWR -> memwrite/regwrite forced 0 that cycle; FETCH1 after release.

Source files
------------

// File: rtl/mips_controller.sv
// Multicycle control FSM for the 8-bit MIPS core: sequences the 4-byte fetch,
// decode and execute phases and drives every datapath select/enable.
module mips_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  output logic       memread_o,
  output logic       memwrite_o,
  output logic       alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] pcsource_o,
  output logic       iord_o,
  output logic       memtoreg_o,
  output logic       regdst_o,
  output logic       regwrite_o,
  output logic [3:0] irwrite_o,
  output logic       pcen_o,
  output logic [2:0] alucont_o,
  output logic       illegal_op_o
);

  // state   | meaning
  // FETCH1-4| read instruction byte n into the IR, PC += 1
  // DECODE  | precompute branch target, dispatch on op
  // MEMADR  | compute load/store address A + imm
  // LBRD    | read data memory at aluout
  // LBWR    | write loaded byte into rt
  // SBWR    | write B to data memory at aluout
  // RTYPEEX | A op B, op chosen by funct
  // RTYPEWR | write aluout into rd
  // BEQEX   | A - B, take branch target if zero
  // JEX     | load jump target into PC
  // ADDIEX  | A + imm
  // ADDIWR  | write aluout into rt

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,  FETCH2  = 4'd1,  FETCH3 = 4'd2,  FETCH4 = 4'd3,
    DECODE  = 4'd4,  MEMADR  = 4'd5,  LBRD   = 4'd6,  LBWR   = 4'd7,
    SBWR    = 4'd8,  RTYPEEX = 4'd9,  RTYPEWR = 4'd10, BEQEX = 4'd11,
    JEX     = 4'd12, ADDIEX  = 4'd13, ADDIWR = 4'd14
  } state_e;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic [3:0] irwrite;
    logic       pcwrite;
    logic       branch;
    logic [2:0] alucont;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d, ctrl_gated;
  logic   op_known;

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_alu = ALU_ADD;
    endcase
  endfunction

  // Outputs of the state about to be entered, so they can be registered.
  function automatic ctrl_t decode_ctrl(input state_e st, input logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (st)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        c.memread = 1'b1;
        c.alusrcb = 2'b01;
        c.pcwrite = 1'b1;
        c.alucont = ALU_ADD;
        case (st)
          FETCH1:  c.irwrite = 4'b0001;
          FETCH2:  c.irwrite = 4'b0010;
          FETCH3:  c.irwrite = 4'b0100;
          default: c.irwrite = 4'b1000;
        endcase
      end
      DECODE: begin
        c.alusrcb = 2'b11;
        c.alucont = ALU_ADD;
      end
      MEMADR, ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.alucont = ALU_ADD;
      end
      LBRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      LBWR: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      SBWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      RTYPEEX: begin
        c.alusrca = 1'b1;
        c.alucont = funct_alu(f);
      end
      RTYPEWR: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      BEQEX: begin
        c.alusrca  = 1'b1;
        c.alucont  = ALU_SUB;
        c.pcsource = 2'b01;
        c.branch   = 1'b1;
      end
      JEX: begin
        c.pcsource = 2'b10;
        c.pcwrite  = 1'b1;
      end
      ADDIWR:  c.regwrite = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    op_known = 1'b1;
    case (op_i)
      OP_RTYPE, OP_LB, OP_SB, OP_BEQ, OP_J, OP_ADDI: op_known = 1'b1;
      default:                                       op_known = 1'b0;
    endcase
  end

  always_comb begin
    state_d = FETCH1;
    case (state_q)
      FETCH1:  state_d = FETCH2;
      FETCH2:  state_d = FETCH3;
      FETCH3:  state_d = FETCH4;
      FETCH4:  state_d = DECODE;
      DECODE: begin
        case (op_i)
          OP_LB, OP_SB: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_J:         state_d = JEX;
          OP_ADDI:      state_d = ADDIEX;
          default:      state_d = FETCH1;
        endcase
      end
      MEMADR:  state_d = (op_i == OP_LB) ? LBRD : SBWR;
      LBRD:    state_d = LBWR;
      RTYPEEX: state_d = RTYPEWR;
      ADDIEX:  state_d = ADDIWR;
      default: state_d = FETCH1;
    endcase
    ctrl_d = decode_ctrl(state_d, funct_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH1;
      ctrl_q  <= decode_ctrl(FETCH1, funct_i);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Reset gates outputs combinationally so an aborted store/writeback never fires.
  assign ctrl_gated   = rst ? '0 : ctrl_q;
  assign memread_o    = ctrl_gated.memread;
  assign memwrite_o   = ctrl_gated.memwrite;
  assign alusrca_o    = ctrl_gated.alusrca;
  assign alusrcb_o    = ctrl_gated.alusrcb;
  assign pcsource_o   = ctrl_gated.pcsource;
  assign iord_o       = ctrl_gated.iord;
  assign memtoreg_o   = ctrl_gated.memtoreg;
  assign regdst_o     = ctrl_gated.regdst;
  assign regwrite_o   = ctrl_gated.regwrite;
  assign irwrite_o    = ctrl_gated.irwrite;
  assign alucont_o    = ctrl_gated.alucont;
  assign pcen_o       = ctrl_gated.pcwrite | (ctrl_gated.branch & zero_i);
  assign illegal_op_o = ~rst & (state_q == DECODE) & ~op_known;

endmodule

// File: tb/tb_mips_controller.sv
// Scoreboard bench for mips_controller: an instruction-level model pushes the
// expected per-cycle control word; a negedge monitor pops and compares.
module tb_mips_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero = 1'b0;
  logic       memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen, illegal_op;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] irwrite;
  logic [2:0] alucont;

  mips_controller dut (
    .clk(clk), .rst(rst), .op_i(op), .funct_i(funct), .zero_i(zero),
    .memread_o(memread), .memwrite_o(memwrite), .alusrca_o(alusrca),
    .alusrcb_o(alusrcb), .pcsource_o(pcsource), .iord_o(iord),
    .memtoreg_o(memtoreg), .regdst_o(regdst), .regwrite_o(regwrite),
    .irwrite_o(irwrite), .pcen_o(pcen), .alucont_o(alucont),
    .illegal_op_o(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       memread, memwrite, alusrca;
    logic [1:0] alusrcb, pcsource;
    logic       iord, memtoreg, regdst, regwrite;
    logic [3:0] irwrite;
    logic       pcwrite, branch;
    logic [2:0] alucont;
    logic       illegal;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Instruction-level reference: one entry per cycle the instruction occupies.
  task automatic issue(input logic [5:0] o, input logic [5:0] f, input bit abort_last);
    exp_t seq[$];
    exp_t e;
    int   n;
    for (int i = 0; i < 4; i++) begin
      e = '0; e.memread = 1; e.irwrite = 4'(1 << i); e.alusrcb = 2'b01;
      e.pcwrite = 1; e.alucont = 3'b010; seq.push_back(e);
    end
    e = '0; e.alusrcb = 2'b11; e.alucont = 3'b010;
    e.illegal = !(o inside {6'b000000, 6'b100000, 6'b101000, 6'b000100, 6'b000010, 6'b001000});
    seq.push_back(e);
    case (o)
      6'b100000, 6'b101000: begin
        e = '0; e.alusrca = 1; e.alusrcb = 2'b10; e.alucont = 3'b010; seq.push_back(e);
        if (o == 6'b100000) begin
          e = '0; e.memread = 1; e.iord = 1; seq.push_back(e);
          e = '0; e.regwrite = 1; e.memtoreg = 1; seq.push_back(e);
        end else begin
          e = '0; e.memwrite = 1; e.iord = 1; seq.push_back(e);
        end
      end
      6'b000000: begin
        e = '0; e.alusrca = 1; e.alucont = funct_alu(f); seq.push_back(e);
        e = '0; e.regwrite = 1; e.regdst = 1; seq.push_back(e);
      end
      6'b000100: begin
        e = '0; e.alusrca = 1; e.alucont = 3'b110; e.pcsource = 2'b01; e.branch = 1;
        seq.push_back(e);
      end
      6'b000010: begin
        e = '0; e.pcsource = 2'b10; e.pcwrite = 1; seq.push_back(e);
      end
      6'b001000: begin
        e = '0; e.alusrca = 1; e.alusrcb = 2'b10; e.alucont = 3'b010; seq.push_back(e);
        e = '0; e.regwrite = 1; seq.push_back(e);
      end
      default: ;
    endcase
    n = abort_last ? seq.size() - 1 : seq.size();
    for (int i = 0; i < n; i++) q.push_back(seq[i]);
    op = o;
    funct = f;
    repeat (n) @(posedge clk);
    #1;
    if (abort_last) begin
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2 zero = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [19:0] obs, expv;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        obs = {memread, memwrite, alusrca, alusrcb, pcsource, iord, memtoreg,
               regdst, regwrite, irwrite, pcen, alucont, illegal_op};
        checks++;
        if (rst) begin
          if (obs !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs t=%0t got=%05h want=00000", $time, obs);
          end
        end else if (q.size() == 0) begin
          errors++;
          $display("FAIL queue_underrun t=%0t got=%05h want=<no cycle expected>", $time, obs);
        end else begin
          e = q.pop_front();
          expv = {e.memread, e.memwrite, e.alusrca, e.alusrcb, e.pcsource, e.iord,
                  e.memtoreg, e.regdst, e.regwrite, e.irwrite,
                  e.pcwrite | (e.branch & zero), e.alucont, e.illegal};
          if (obs !== expv) begin
            errors++;
            $display("FAIL ctrl_word t=%0t op=%06b funct=%06b zero=%0b got=%05h want=%05h",
                     $time, op, funct, zero, obs, expv);
          end
        end
      end
    end
  end

  initial begin
    logic [5:0] ops [6];
    logic [5:0] fns [5];
    logic [5:0] o, f;
    ops = '{6'b000000, 6'b100000, 6'b101000, 6'b000100, 6'b000010, 6'b001000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rst = 1'b1;
    op = 6'b0;
    funct = 6'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(6'b000000, 6'b101010, 1'b0);
    issue(6'b100000, 6'b000000, 1'b0);
    issue(6'b101000, 6'b000000, 1'b0);
    issue(6'b000100, 6'b000000, 1'b0);
    issue(6'b000100, 6'b000000, 1'b0);
    issue(6'b000010, 6'b000000, 1'b0);
    issue(6'b111111, 6'b000000, 1'b0);
    issue(6'b101000, 6'b000000, 1'b1);
    issue(6'b000000, 6'b100010, 1'b1);
    issue(6'b001000, 6'b000000, 1'b0);

    for (int i = 0; i < 80; i++) begin
      o = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      issue(o, f, ($urandom_range(0, 9) == 0) && (o inside {6'b101000, 6'b000000}));
    end
    mon_en = 1'b0;

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained got=%0d entries want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
